// File: rtl/draw_sequencer.sv
// Round-robin sequencer sharing one VGA pixel port between drawing engines.
// Optional watchdog abort in RUN: define DRAW_WATCHDOG_EN.
module draw_sequencer #(
    parameter int NUM_ENG        = 3,
    parameter int TIMEOUT_CYCLES = 32768,
    localparam int IDW           = $clog2(NUM_ENG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_ENG-1:0]   req,
    output logic [NUM_ENG-1:0]   ack,
    output logic [NUM_ENG-1:0]   eng_start,
    input  logic [NUM_ENG-1:0]   eng_done,
    input  logic [8*NUM_ENG-1:0] eng_x,
    input  logic [7*NUM_ENG-1:0] eng_y,
    input  logic [3*NUM_ENG-1:0] eng_colour,
    input  logic [NUM_ENG-1:0]   eng_plot,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot,
    output logic                 busy,
    output logic [IDW-1:0]       cur_eng,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE,
        S_ACK
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     cur_eng_q, cur_eng_d;
    logic [NUM_ENG-1:0] start_q, start_d;
    logic [NUM_ENG-1:0] ack_q, ack_d;
    logic               err_d;

    logic               gnt_found;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     cand;
    int                 cur_i;
    logic               cur_done;

    assign cur_i    = int'(cur_eng_q);
    assign cur_done = eng_done[cur_eng_q];

    // Search starts just after the last grant so the previous owner goes last.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = cur_eng_q;
        cand      = '0;
        for (int k = 1; k <= NUM_ENG; k++) begin
            cand = IDW'((cur_i + k) % NUM_ENG);
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

`ifdef DRAW_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        wd_fire;
    logic        err_q;

    assign wd_fire = (state_q == S_RUN) && !cur_done
                     && (wd_cnt_q == WD_LAST);

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == S_IDLE) begin
            wd_cnt_d = '0;
        end else if (state_q == S_RUN) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    logic        wd_fire;
    logic        unused_err_d;
    logic [31:0] unused_timeout;

    assign wd_fire        = 1'b0;
    assign err            = 1'b0;
    assign unused_err_d   = err_d;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d   = state_q;
        cur_eng_d = cur_eng_q;
        start_d   = start_q;
        ack_d     = '0;
        err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    state_d   = S_RUN;
                    cur_eng_d = gnt_idx;
                    start_d   = NUM_ENG'(1) << gnt_idx;
                end
            end
            S_RUN: begin
                if (cur_done || wd_fire) begin
                    state_d = S_RELEASE;
                    start_d = '0;
                    err_d   = wd_fire;
                end
            end
            S_RELEASE: begin
                if (!cur_done) begin
                    state_d = S_ACK;
                    ack_d   = NUM_ENG'(1) << cur_eng_q;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                start_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cur_eng_q <= IDW'(NUM_ENG - 1);
            start_q   <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_eng_q <= cur_eng_d;
            start_q   <= start_d;
            ack_q     <= ack_d;
        end
    end

    // Pixel path is a pure mux so engine timing reaches the adapter unchanged.
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (state_q == S_RUN) begin
            vga_x      = eng_x[8*cur_i +: 8];
            vga_y      = eng_y[7*cur_i +: 7];
            vga_colour = eng_colour[3*cur_i +: 3];
            vga_plot   = eng_plot[cur_eng_q];
        end
    end

    assign eng_start = start_q;
    assign ack       = ack_q;
    assign busy      = (state_q != S_IDLE);
    assign cur_eng   = cur_eng_q;

endmodule
